// File: rtl/hwpe_multistream_sched_pkg.sv
// Shared types and limits for the multi-stream HWPE scheduler.
package hwpe_multistream_sched_package;

    localparam int unsigned MAX_N_IN  = 8;
    localparam int unsigned MAX_N_OUT = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_START    = 2'd1,
        ST_COMPUTE  = 2'd2,
        ST_FINISHED = 2'd3
    } sched_state_e;

endpackage

// File: rtl/hwpe_multistream_sched_if.sv
// Streamer handshake bundle between the scheduler (master) and its input/output streamers (slave).
interface hwpe_multistream_sched_if #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_OUT = 1
) ();

    logic [N_IN-1:0]  in_start_o;
    logic [N_IN-1:0]  in_ready_i;
    logic [N_IN-1:0]  in_done_i;
    logic [N_OUT-1:0] out_start_o;
    logic [N_OUT-1:0] out_ready_i;
    logic [N_OUT-1:0] out_beat_i;

    modport master (
        output in_start_o, out_start_o,
        input  in_ready_i, in_done_i, out_ready_i, out_beat_i
    );

    modport slave (
        input  in_start_o, out_start_o,
        output in_ready_i, in_done_i, out_ready_i, out_beat_i
    );

endinterface

// File: rtl/hwpe_ms_beat_cnt.sv
// Per-output beat counter: counts handshaked beats up to a limit, then holds and flags extra beats.
module hwpe_ms_beat_cnt
    import hwpe_multistream_sched_package::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             beat,
    input  logic [CNT_W-1:0] limit,
    output logic             cmpl,
    output logic             ovf_c
);

    logic [CNT_W-1:0] cnt_q;

    // A beat arriving after the stream already completed is an overflow.
    assign ovf_c = en & beat & cmpl;

    // Count beats; the beat that finds cnt==limit completes the stream and the count holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            cmpl  <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            cmpl  <= 1'b0;
        end else if (en && beat && !cmpl) begin
            if (cnt_q == limit) begin
                cmpl <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hwpe_multistream_sched.sv
// Multi-stream job scheduler: issues streamers, launches the engine, tracks completion per iteration.
module hwpe_multistream_sched
    import hwpe_multistream_sched_package::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 1,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ITER_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [ITER_W-1:0]        nb_iter_i,
    input  logic [N_OUT*CNT_W-1:0]   cnt_limit_i,
    hwpe_multistream_sched_if.master strm,
    output logic                     engine_start_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [ITER_W-1:0]        iter_o
);

    sched_state_e             state_q, state_d;
    logic [N_IN-1:0]          in_issued_q, in_issued_d;
    logic [N_IN-1:0]          in_cmpl_q, in_cmpl_d;
    logic [N_IN-1:0]          in_start_q, in_start_d;
    logic [N_OUT-1:0]         out_issued_q, out_issued_d;
    logic [N_OUT-1:0]         out_start_q, out_start_d;
    logic [N_OUT-1:0]         out_cmpl;
    logic [N_OUT-1:0]         out_ovf;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic [ITER_W-1:0]        nb_iter_q, nb_iter_d;
    logic [N_OUT*CNT_W-1:0]   limit_q, limit_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     eng_q, eng_d;
    logic                     cnt_clear_c;
    logic                     cnt_en_c;

    assign strm.in_start_o  = in_start_q;
    assign strm.out_start_o = out_start_q;
    assign engine_start_o   = eng_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign iter_o           = iter_q;

    // One beat counter per output stream, cleared at job start, iteration turnaround and soft clear.
    for (genvar j = 0; j < N_OUT; j++) begin : g_cnt
        hwpe_ms_beat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk_i),
            .rst   (rst_i),
            .clear (cnt_clear_c),
            .en    (cnt_en_c),
            .beat  (strm.out_beat_i[j]),
            .limit (limit_q[j*CNT_W +: CNT_W]),
            .cmpl  (out_cmpl[j]),
            .ovf_c (out_ovf[j])
        );
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            in_issued_q  <= '0;
            in_cmpl_q    <= '0;
            in_start_q   <= '0;
            out_issued_q <= '0;
            out_start_q  <= '0;
            iter_q       <= '0;
            nb_iter_q    <= '0;
            limit_q      <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            eng_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_issued_q  <= in_issued_d;
            in_cmpl_q    <= in_cmpl_d;
            in_start_q   <= in_start_d;
            out_issued_q <= out_issued_d;
            out_start_q  <= out_start_d;
            iter_q       <= iter_d;
            nb_iter_q    <= nb_iter_d;
            limit_q      <= limit_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            eng_q        <= eng_d;
        end
    end

    // Next-state and next-output logic; soft clear overrides everything else.
    always_comb begin
        state_d      = state_q;
        in_issued_d  = in_issued_q;
        in_cmpl_d    = in_cmpl_q;
        out_issued_d = out_issued_q;
        iter_d       = iter_q;
        nb_iter_d    = nb_iter_q;
        limit_d      = limit_q;
        err_d        = err_q;
        cnt_clear_c  = 1'b0;
        cnt_en_c     = (state_q == ST_START) || (state_q == ST_COMPUTE);

        if (cnt_en_c) begin
            in_cmpl_d = in_cmpl_q | strm.in_done_i;
            err_d     = err_q | (|out_ovf);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    nb_iter_d    = nb_iter_i;
                    limit_d      = cnt_limit_i;
                    iter_d       = '0;
                    err_d        = 1'b0;
                    in_issued_d  = '0;
                    out_issued_d = '0;
                    in_cmpl_d    = '0;
                    cnt_clear_c  = 1'b1;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                in_issued_d  = in_issued_q  | (in_start_q  & strm.in_ready_i);
                out_issued_d = out_issued_q | (out_start_q & strm.out_ready_i);
                if ((&in_issued_d) && (&out_issued_d)) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if ((&in_cmpl_q) && (&out_cmpl)) begin
                    if (iter_q == nb_iter_q) begin
                        state_d = ST_FINISHED;
                    end else begin
                        iter_d       = iter_q + ITER_W'(1);
                        in_issued_d  = '0;
                        out_issued_d = '0;
                        in_cmpl_d    = '0;
                        cnt_clear_c  = 1'b1;
                        state_d      = ST_START;
                    end
                end
            end
            ST_FINISHED: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear_i) begin
            state_d      = ST_IDLE;
            in_issued_d  = '0;
            out_issued_d = '0;
            in_cmpl_d    = '0;
            iter_d       = '0;
            nb_iter_d    = '0;
            limit_d      = '0;
            err_d        = 1'b0;
            cnt_clear_c  = 1'b1;
        end

        in_start_d  = (state_d == ST_START) ? ~in_issued_d  : '0;
        out_start_d = (state_d == ST_START) ? ~out_issued_d : '0;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISHED);
        eng_d       = (state_d == ST_COMPUTE) && (state_q != ST_COMPUTE);
    end

endmodule

// File: tb/tb_hwpe_multistream_sched.sv
// Scoreboard bench for the multi-stream scheduler: expected engine/done events queued at job issue.
module tb_hwpe_multistream_sched;

    localparam int unsigned N_IN   = 2;
    localparam int unsigned N_OUT  = 1;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned ITER_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clear;
    logic                   start;
    logic [ITER_W-1:0]      nb_iter;
    logic [N_OUT*CNT_W-1:0] cnt_limit;
    logic                   engine_start;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [ITER_W-1:0]      iter;

    hwpe_multistream_sched_if #(.N_IN(N_IN), .N_OUT(N_OUT)) sif ();

    hwpe_multistream_sched #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .CNT_W  (CNT_W),
        .ITER_W (ITER_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .start_i        (start),
        .nb_iter_i      (nb_iter),
        .cnt_limit_i    (cnt_limit),
        .strm           (sif),
        .engine_start_o (engine_start),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .iter_o         (iter)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int it;
        bit err;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: every engine launch or job-end pulse must match the next queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (engine_start === 1'b1 || done === 1'b1) begin
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: engine=%0b done=%0b with nothing expected", engine_start, done);
                end else begin
                    e = expq.pop_front();
                    check("event_kind_is_done", done, e.is_done);
                    check("event_iter", iter, e.it);
                    if (e.is_done) check("done_err", err, e.err);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic recover();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sif.out_beat_i = '0;
        sif.in_done_i  = '0;
        expq.delete();
    endtask

    task automatic wait_engine(output bit ok, input bit rand_ready);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rand_ready) begin
                sif.in_ready_i  = N_IN'($urandom);
                sif.out_ready_i = N_OUT'($urandom);
            end
            @(negedge clk);
            if (engine_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL engine_wait: engine_start_o=0 after 200 cycles, required 1");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_wait: busy_o=1 after 50 cycles, required 0");
            recover();
        end
    endtask

    // Randomised job: each iteration needs lim+1 beats and one done per input; extra beats flag an error.
    task automatic run_job(input int nb, input int lim, input int extra);
        bit ok;
        int beats;
        int target;
        bit [N_IN-1:0] dn;
        for (int i = 0; i <= nb; i++) expq.push_back('{1'b0, i, 1'b0});
        expq.push_back('{1'b1, nb, (extra > 0)});
        tick();
        start     = 1'b1;
        nb_iter   = ITER_W'(nb);
        cnt_limit = {N_OUT{CNT_W'(lim)}};
        tick();
        start     = 1'b0;
        nb_iter   = ITER_W'($urandom);
        cnt_limit = {N_OUT{CNT_W'($urandom)}};
        for (int it = 0; it <= nb; it++) begin
            wait_engine(ok, 1'b1);
            if (!ok) begin
                recover();
                return;
            end
            target = lim + 1 + ((it == 0) ? extra : 0);
            beats  = 0;
            dn     = '0;
            for (int c = 0; c < 500 && (beats < target || dn != {N_IN{1'b1}}); c++) begin
                sif.out_beat_i = '0;
                sif.in_done_i  = '0;
                for (int i = 0; i < N_IN; i++) begin
                    if (!dn[i] && (i != 0 || beats >= target) && $urandom_range(0, 2) == 0) begin
                        sif.in_done_i[i] = 1'b1;
                        dn[i] = 1'b1;
                    end else if (dn[i] && i != 0 && !dn[0] && $urandom_range(0, 3) == 0) begin
                        sif.in_done_i[i] = 1'b1;
                    end
                end
                if (beats < target && $urandom_range(0, 2) != 0) begin
                    sif.out_beat_i = {N_OUT{1'b1}};
                    beats++;
                end
                tick();
            end
            sif.out_beat_i = '0;
            sif.in_done_i  = '0;
        end
        wait_idle();
        check("queue_drained", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        bit ok;
        rst             = 1'b1;
        clear           = 1'b0;
        start           = 1'b0;
        nb_iter         = '0;
        cnt_limit       = '0;
        sif.in_ready_i  = '0;
        sif.in_done_i   = '0;
        sif.out_ready_i = '0;
        sif.out_beat_i  = '0;

        // Outputs while reset is held.
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_engine", engine_start, 0);
        check("rst_iter", iter, 0);
        check("rst_in_start", sif.in_start_o, 0);
        check("rst_out_start", sif.out_start_o, 0);
        tick();
        tick();
        rst = 1'b0;

        // Basic single-iteration job with cycle-exact timing.
        sif.in_ready_i  = '1;
        sif.out_ready_i = '1;
        expq.push_back('{1'b0, 0, 1'b0});
        expq.push_back('{1'b1, 0, 1'b0});
        tick();
        start     = 1'b1;
        nb_iter   = '0;
        cnt_limit = {N_OUT{CNT_W'(3)}};
        tick();
        start     = 1'b0;
        @(negedge clk);
        check("t1_in_start", sif.in_start_o, 2'b11);
        check("t1_out_start", sif.out_start_o, 1);
        check("t1_engine", engine_start, 0);
        check("t1_busy", busy, 1);
        tick();
        @(negedge clk);
        check("t2_engine", engine_start, 1);
        check("t2_in_start", sif.in_start_o, 0);
        for (int k = 0; k < 4; k++) begin
            sif.out_beat_i = '1;
            sif.in_done_i  = (k == 3) ? {N_IN{1'b1}} : '0;
            tick();
        end
        sif.out_beat_i = '0;
        sif.in_done_i  = '0;
        @(negedge clk);
        check("t_last_done_early", done, 0);
        tick();
        @(negedge clk);
        check("t_done", done, 1);
        check("t_done_err", err, 0);
        tick();
        @(negedge clk);
        check("t_after_done", done, 0);
        check("t_after_busy", busy, 0);

        // Input stream 1 stalls its acceptance for five cycles.
        sif.in_ready_i  = 2'b01;
        sif.out_ready_i = '1;
        expq.push_back('{1'b0, 0, 1'b0});
        expq.push_back('{1'b1, 0, 1'b0});
        tick();
        start     = 1'b1;
        nb_iter   = '0;
        cnt_limit = '0;
        tick();
        start     = 1'b0;
        @(negedge clk);
        check("stall_c1_in_start", sif.in_start_o, 2'b11);
        for (int k = 2; k <= 6; k++) begin
            tick();
            @(negedge clk);
            check("stall_in_start", sif.in_start_o, 2'b10);
            check("stall_out_start", sif.out_start_o, 0);
            check("stall_engine", engine_start, 0);
            if (k == 6) sif.in_ready_i = '1;
        end
        tick();
        @(negedge clk);
        check("stall_engine_late", engine_start, 1);
        sif.out_beat_i = '1;
        sif.in_done_i  = '1;
        tick();
        sif.out_beat_i = '0;
        sif.in_done_i  = '0;
        wait_idle();
        expq.delete();

        // Three iterations with single-beat limit, then a five-beat overflow job.
        run_job(2, 0, 0);
        run_job(0, 3, 1);

        // Soft clear in COMPUTE after two beats.
        sif.in_ready_i  = '1;
        sif.out_ready_i = '1;
        expq.push_back('{1'b0, 0, 1'b0});
        expq.push_back('{1'b1, 0, 1'b0});
        tick();
        start     = 1'b1;
        nb_iter   = '0;
        cnt_limit = {N_OUT{CNT_W'(3)}};
        tick();
        start     = 1'b0;
        wait_engine(ok, 1'b0);
        sif.out_beat_i = '1;
        tick();
        tick();
        sif.out_beat_i = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("clr_busy", busy, 0);
        check("clr_iter", iter, 0);
        check("clr_err", err, 0);
        check("clr_in_start", sif.in_start_o, 0);
        check("clr_done_pending", expq.size(), 1);
        expq.delete();
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("clr_no_done", done, 0);
        end
        // Clear beats a simultaneous start.
        tick();
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        check("clr_vs_start_busy", busy, 0);
        check("clr_vs_start_in_start", sif.in_start_o, 0);
        run_job(0, 3, 0);

        // Largest limit: a few beats never complete the stream or overflow.
        sif.in_ready_i  = '1;
        sif.out_ready_i = '1;
        expq.push_back('{1'b0, 0, 1'b0});
        tick();
        start     = 1'b1;
        nb_iter   = '0;
        cnt_limit = '1;
        tick();
        start     = 1'b0;
        wait_engine(ok, 1'b0);
        sif.out_beat_i = '1;
        sif.in_done_i  = '1;
        for (int k = 0; k < 3; k++) tick();
        sif.out_beat_i = '0;
        sif.in_done_i  = '0;
        tick();
        tick();
        @(negedge clk);
        check("maxlim_busy", busy, 1);
        check("maxlim_err", err, 0);
        recover();

        // Reset mid-COMPUTE after an overflow.
        expq.push_back('{1'b0, 0, 1'b0});
        expq.push_back('{1'b1, 0, 1'b1});
        tick();
        start     = 1'b1;
        nb_iter   = '0;
        cnt_limit = '0;
        tick();
        start     = 1'b0;
        wait_engine(ok, 1'b0);
        sif.out_beat_i = '1;
        tick();
        tick();
        sif.out_beat_i = '0;
        @(negedge clk);
        check("pre_rst_err", err, 1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_engine", engine_start, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_iter", iter, 0);
        check("mid_rst_in_start", sif.in_start_o, 0);
        check("mid_rst_out_start", sif.out_start_o, 0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_done_pending", expq.size(), 1);
        expq.delete();
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end

        // Randomised jobs.
        for (int k = 0; k < 12; k++) begin
            run_job($urandom_range(0, 3), $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_multistream_sched.md
HWPE_MULTISTREAM_SCHED -- requirements
Module: hwpe_multistream_sched

Interface
REQ-001 SHALL have parameter N_IN, default 2, number of input streams (1..8).
REQ-002 SHALL have parameter N_OUT, default 1, number of output streams (1..8).
REQ-003 SHALL have parameter CNT_W, default 32, output beat-counter width.
REQ-004 SHALL have parameter ITER_W, default 16, iteration-counter width.
REQ-005 SHALL have port clk_i  in  1  the only clock; all state on rising edge.
REQ-006 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port clear_i  in  1  synchronous soft clear from the slave.
REQ-008 SHALL have port start_i  in  1  one-cycle job trigger.
REQ-009 SHALL have port nb_iter_i  in  ITER_W  iterations minus one.
REQ-010 SHALL have port cnt_limit_i  in  N_OUT x CNT_W  per-output beats-per-iteration minus one.
REQ-011 SHALL have port in_start_o / in_ready_i / in_done_i  out/in/in  N_IN each  input streamer start request, acceptance, completion pulse.
REQ-012 SHALL have port out_start_o / out_ready_i / out_beat_i  out/in/in  N_OUT each  output streamer start request, acceptance, handshaked beat.
REQ-013 SHALL have port engine_start_o  out  1  one-cycle engine launch pulse.
REQ-014 SHALL have port busy_o, done_o, err_o  out  1 each  job active, one-cycle job-end pulse, sticky overflow.
REQ-015 SHALL have port iter_o  out  ITER_W  current iteration index.

Function
REQ-016 SHALL implement states IDLE, START, COMPUTE, FINISHED.
REQ-017 IDLE: start_i latches nb_iter_i and cnt_limit_i, sets iter_o=0, clears err_o, moves to START next cycle; start_i outside IDLE SHALL be ignored.
REQ-018 START: in_start_o[i] = state START and stream i not yet issued; issued[i] sets when in_start_o[i] and in_ready_i[i]; same rule for out_start_o.
REQ-019 When all N_IN+N_OUT issued bits are set (including bits set that cycle), FSM SHALL enter COMPUTE; engine_start_o SHALL be high exactly the first COMPUTE cycle.
REQ-020 in_done_i[i] SHALL set in_cmpl[i] in START or COMPUTE; repeated pulses ignored.
REQ-021 out_beat_i[j] SHALL increment count[j] in START or COMPUTE; when count[j]==limit[j] on a beat, out_cmpl[j] sets and count holds.
REQ-022 A beat on a completed output stream SHALL set err_o, leaving count unchanged.
REQ-023 Final beat and in_done_i in the same cycle SHALL both be recorded that cycle.
REQ-024 In COMPUTE, when all in_cmpl and out_cmpl are set: if iter_o==nb_iter latched, go FINISHED; else iter_o+1, clear issued, cmpl and counters, go START (one cycle turnaround).
REQ-025 FINISHED: done_o high one cycle, then IDLE; busy_o SHALL be high in START, COMPUTE, FINISHED.
REQ-026 clear_i SHALL return to IDLE next cycle, zero all counters and flags, suppress done_o; clear_i wins over every other event.
REQ-027 Arithmetic unsigned; limit 0 means 1 beat; limit 2^CNT_W-1 legal.

Reset
REQ-028 rst_i SHALL asynchronously force IDLE, all counters, issued/cmpl bits, latched parameters, iter_o, err_o to 0.
REQ-029 During reset all outputs SHALL be 0.
REQ-030 Reset mid-job SHALL abandon the job with no done_o pulse.

Structure
REQ-031 State enum and N_IN/N_OUT max constants SHALL live in package hwpe_multistream_sched_package.
REQ-032 Per-output counter with limit compare, saturation and overflow flag SHALL be sub-module hwpe_ms_beat_cnt, instantiated N_OUT times.

Verification
REQ-033 N_IN=2, N_OUT=1, nb_iter=0, limit=3, all ready: start at t -> in/out_start_o at t+1, engine_start_o t+2, 4 beats + 2 in_done -> done_o next-but-one cycle, err_o=0.
REQ-034 in_ready_i[1] held low 5 cycles -> in_start_o[1] stays high, in_start_o[0] drops after accept, engine_start_o delayed 5 cycles.
REQ-035 nb_iter=2, limit=0 -> three START/COMPUTE rounds, iter_o 0,1,2, single done_o.
REQ-036 5 beats with limit=3 -> err_o set on 5th beat, job still completes with done_o.
REQ-037 clear_i in COMPUTE after 2 beats -> IDLE next cycle, counters 0, no done_o; new start runs clean.
REQ-038 rst_i asserted mid-COMPUTE -> all outputs 0 immediately, no done_o after release.
